// File: rtl/mycpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mycpu_pkg
//  Description : Shared types and widths for the data SRAM interface.
//  Revision    : 1.0 - initial release
// ============================================================================
package mycpu_pkg;

    localparam int DATA_SRAM_AW = 32;
    localparam int DATA_SRAM_DW = 32;
    localparam int DATA_SRAM_NB = DATA_SRAM_DW / 8;

    typedef struct packed {
        logic                    en;
        logic [DATA_SRAM_NB-1:0] wen;
        logic [DATA_SRAM_AW-1:0] addr;
        logic [DATA_SRAM_DW-1:0] wdata;
    } dsram_req_t;

    function automatic logic dsram_is_write(input dsram_req_t req);
        return req.en && (req.wen != '0);
    endfunction

    function automatic logic dsram_is_read(input dsram_req_t req);
        return req.en && (req.wen == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_sram_bank.sv
`default_nettype none
// ============================================================================
//  Module      : data_sram_bank
//  Description : DEPTH x 32 storage, per-byte write enables, registered read.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_sram_bank
    import mycpu_pkg::*;
#(
    parameter int DEPTH_LOG2 = 14
) (
    input  logic                    clk,
    input  logic [DATA_SRAM_NB-1:0] we,
    input  logic                    re,
    input  logic [DEPTH_LOG2-1:0]   idx,
    input  logic [DATA_SRAM_DW-1:0] wdata,
    output logic [DATA_SRAM_DW-1:0] rdata
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    // One byte-wide array per lane keeps each lane's write port independent.
    generate
        for (genvar i = 0; i < DATA_SRAM_NB; i++) begin : g_lane
            logic [7:0] r_mem [c_DEPTH];
            logic [7:0] r_rdata;

            always_ff @(posedge clk) begin
                if (we[i]) begin
                    r_mem[idx] <= wdata[8*i +: 8];
                end
                if (re) begin
                    r_rdata <= r_mem[idx];
                end
            end

            assign rdata[8*i +: 8] = r_rdata;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/data_sram_resp.sv
`default_nettype none
// ============================================================================
//  Module      : data_sram_resp
//  Description : Data SRAM responder: byte-lane writes, 1-cycle reads,
//                saturating access counters. Optional range checking is
//                enabled by defining DATA_SRAM_RANGE_CHK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_sram_resp
    import mycpu_pkg::*;
#(
    parameter int DEPTH_LOG2 = 14,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    data_sram_en,
    input  logic [DATA_SRAM_NB-1:0] data_sram_wen,
    input  logic [DATA_SRAM_AW-1:0] data_sram_addr,
    input  logic [DATA_SRAM_DW-1:0] data_sram_wdata,
    output logic [DATA_SRAM_DW-1:0] data_sram_rdata,
    output logic [CNT_W-1:0]        rd_cnt,
    output logic [CNT_W-1:0]        wr_cnt,
    output logic                    addr_err
);

    dsram_req_t              w_req;
    logic                    w_rd;
    logic                    w_wr;
    logic                    w_oor;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic [DATA_SRAM_NB-1:0] w_bank_we;
    logic                    w_bank_re;
    logic [DATA_SRAM_DW-1:0] w_bank_rdata;

    logic                    r_rd_fire;
    logic                    r_rd_oor;
    logic [DATA_SRAM_DW-1:0] r_rdata_hold;
    logic [CNT_W-1:0]        r_rd_cnt;
    logic [CNT_W-1:0]        r_wr_cnt;

    // A request presented while reset is held must not touch the array.
    assign w_req = '{
        en:    data_sram_en & resetn,
        wen:   data_sram_wen,
        addr:  data_sram_addr,
        wdata: data_sram_wdata
    };

    assign w_rd  = dsram_is_read(w_req);
    assign w_wr  = dsram_is_write(w_req);
    assign w_idx = w_req.addr[DEPTH_LOG2+1:2];

`ifdef DATA_SRAM_RANGE_CHK_EN
    logic r_addr_err;
    logic w_unused_addr;

    assign w_oor         = |w_req.addr[DATA_SRAM_AW-1:DEPTH_LOG2+2];
    assign w_unused_addr = &{1'b0, w_req.addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr_err <= 1'b0;
        end else if (w_req.en && w_oor) begin
            r_addr_err <= 1'b1;
        end
    end

    assign addr_err = r_addr_err;
`else
    logic w_unused_addr;

    // Upper address bits are ignored, so accesses alias modulo the depth.
    assign w_oor         = 1'b0;
    assign w_unused_addr = &{1'b0, w_req.addr[DATA_SRAM_AW-1:DEPTH_LOG2+2], w_req.addr[1:0]};
    assign addr_err      = 1'b0;
`endif

    assign w_bank_we = (w_wr && !w_oor) ? w_req.wen : '0;
    assign w_bank_re = w_rd && !w_oor;

    data_sram_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
        .clk   (clk),
        .we    (w_bank_we),
        .re    (w_bank_re),
        .idx   (w_idx),
        .wdata (w_req.wdata),
        .rdata (w_bank_rdata)
    );

    // Read path: the bank's read register carries no reset, so the visible
    // rdata is muxed against a resettable hold copy of the last output.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_fire    <= 1'b0;
            r_rd_oor     <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            r_rd_fire    <= w_rd;
            r_rd_oor     <= w_rd & w_oor;
            r_rdata_hold <= data_sram_rdata;
        end
    end

    assign data_sram_rdata = !r_rd_fire ? r_rdata_hold :
                             r_rd_oor   ? '0           : w_bank_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd && (r_rd_cnt != '1)) begin
                r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
            if (w_wr && (r_wr_cnt != '1)) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
        end
    end

    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_sram_resp
//  Description : Self-checking bench for data_sram_resp with a reference model
//                and a read-response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_resp;

    localparam int DEPTH_LOG2 = 14;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic              clk    = 1'b0;
    logic              resetn = 1'b0;
    logic              en     = 1'b0;
    logic [3:0]        wen    = 4'h0;
    logic [31:0]       addr   = 32'h0;
    logic [31:0]       wdata  = 32'h0;
    logic [31:0]       rdata;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  wr_cnt;
    logic              addr_err;

    int n_checks = 0;
    int n_fails  = 0;

    bit [31:0] mdl_mem [int];
    int        mdl_rd;
    int        mdl_wr;
    bit        mdl_err;
    bit [31:0] mdl_rdata;
    bit [31:0] exp_q [$];

    data_sram_resp #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .rd_cnt          (rd_cnt),
        .wr_cnt          (wr_cnt),
        .addr_err        (addr_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mdl_rd    = 0;
        mdl_wr    = 0;
        mdl_err   = 1'b0;
        mdl_rdata = 32'h0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus, advance the model, then compare outputs.
    task automatic access(input string tag, input bit e, input bit [3:0] w,
                          input bit [31:0] a, input bit [31:0] d);
        bit        oor;
        int        idx;
        bit [31:0] word;
        @(negedge clk);
        en    = e;
        wen   = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        en = 1'b0;
`ifdef DATA_SRAM_RANGE_CHK_EN
        oor = (a[31:DEPTH_LOG2+2] != '0);
`else
        oor = 1'b0;
`endif
        idx = int'(a[DEPTH_LOG2+1:2]);
        if (e) begin
            if (oor) mdl_err = 1'b1;
            if (w != 4'h0) begin
                if (mdl_wr < CNT_MAX) mdl_wr++;
                if (!oor) begin
                    word = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
                    for (int i = 0; i < 4; i++) begin
                        if (w[i]) word[8*i +: 8] = d[8*i +: 8];
                    end
                    mdl_mem[idx] = word;
                end
            end else begin
                if (mdl_rd < CNT_MAX) mdl_rd++;
                exp_q.push_back(oor ? 32'h0 : mdl_mem[idx]);
            end
        end
        if (exp_q.size() > 0) mdl_rdata = exp_q.pop_front();
        check_eq({tag, ".rdata"}, rdata, mdl_rdata);
        check_eq({tag, ".rd_cnt"}, 32'(rd_cnt), 32'(mdl_rd));
        check_eq({tag, ".wr_cnt"}, 32'(wr_cnt), 32'(mdl_wr));
        check_eq({tag, ".addr_err"}, 32'(addr_err), 32'(mdl_err));
    endtask

    initial begin
        bit [3:0]  r_wen;
        bit [31:0] r_addr;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("por.rdata", rdata, 32'h0);
        check_eq("por.rd_cnt", 32'(rd_cnt), 32'h0);
        check_eq("por.wr_cnt", 32'(wr_cnt), 32'h0);
        check_eq("por.addr_err", 32'(addr_err), 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Write then read
        access("wr100", 1'b1, 4'hF, 32'h100, 32'h1234_5678);
        access("rd100", 1'b1, 4'h0, 32'h100, 32'h0);
        check_eq("rd100.spec", rdata, 32'h1234_5678);

        // Partial byte-lane write merged over the old word
        access("wrlane", 1'b1, 4'b0101, 32'h100, 32'hAABB_CCDD);
        access("rdlane", 1'b1, 4'h0, 32'h100, 32'h0);
        check_eq("rdlane.spec", rdata, 32'h12BB_56DD);

        // Back-to-back write/read, then an idle cycle holds rdata
        access("wr200", 1'b1, 4'hF, 32'h200, 32'hCAFE_F00D);
        access("rd200", 1'b1, 4'h0, 32'h200, 32'h0);
        access("idle", 1'b0, 4'h0, 32'h200, 32'hFFFF_FFFF);
        check_eq("idle.spec", rdata, 32'hCAFE_F00D);

        // Out-of-range / aliasing
        access("wr0", 1'b1, 4'hF, 32'h0, 32'h1122_3344);
        access("wroor", 1'b1, 4'hF, 32'h0001_0000, 32'hDEAD_BEEF);
        access("rd0", 1'b1, 4'h0, 32'h0, 32'h0);
`ifdef DATA_SRAM_RANGE_CHK_EN
        check_eq("rd0.spec", rdata, 32'h1122_3344);
        check_eq("oor.err", 32'(addr_err), 32'h1);
`else
        check_eq("rd0.spec", rdata, 32'hDEAD_BEEF);
        check_eq("oor.err", 32'(addr_err), 32'h0);
`endif
        access("rdoor", 1'b1, 4'h0, 32'h0001_0000, 32'h0);

        // Mid-cycle async reset: outputs clear immediately
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_eq("rst.rdata", rdata, 32'h0);
        check_eq("rst.rd_cnt", 32'(rd_cnt), 32'h0);
        check_eq("rst.wr_cnt", 32'(wr_cnt), 32'h0);
        check_eq("rst.addr_err", 32'(addr_err), 32'h0);
        // A write presented during reset is dropped
        en    = 1'b1;
        wen   = 4'hF;
        addr  = 32'h200;
        wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        en     = 1'b0;
        resetn = 1'b1;
        access("rdrst", 1'b1, 4'h0, 32'h200, 32'h0);
        check_eq("rdrst.spec", rdata, 32'hCAFE_F00D);

        // Randomised traffic over a pre-filled window
        for (int i = 16; i < 32; i++) begin
            access("fill", 1'b1, 4'hF, 32'(i * 4), $urandom);
        end
        for (int n = 0; n < 40; n++) begin
            r_wen  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            r_addr = 32'($urandom_range(16, 31) * 4);
            access("rand", ($urandom_range(0, 4) != 0), r_wen, r_addr, $urandom);
        end

        // Read counter saturation from a fresh reset
        @(negedge clk);
        resetn = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        for (int n = 0; n < 20; n++) begin
            access("sat", 1'b1, 4'h0, 32'h100, 32'h0);
        end
        check_eq("sat.spec", 32'(rd_cnt), 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
